mem_cmd_sequencer: RTL and testbench

- Sits directly downstream of instruction_decoder and consumes its decoded fields.
- Executes single-word writes into the 15-bit-address on-chip buffer RAM.
- Executes burst reads from the RAM over an inclusive address range, streaming the words out on a valid/ready interface.
- Emits a one-cycle go pulse to the compute core once all earlier commands have retired.

---
 rtl/mem_seq_pkg.sv | 46 ++++
 rtl/mem_cmd_sequencer_rd_skid_buffer.sv | 72 +++++++
 rtl/mem_cmd_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared types and defaults for the memory command sequencer.
//               Holds the RAM address/data width defaults, the sequencer
//               state enum, the decoded-command struct and the decode helper
//               that applies write > read > go priority.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

    localparam int MEM_ADDR_W = 15;
    localparam int MEM_DATA_W = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        GO    = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_WR  = 2'd1,
        OP_RD  = 2'd2,
        OP_GO  = 2'd3
    } op_t;

    // addr_a carries wr_addr for writes and rd_start_addr for reads;
    // addr_b carries rd_end_addr.
    typedef struct packed {
        op_t                   op;
        logic [MEM_ADDR_W-1:0] addr_a;
        logic [MEM_ADDR_W-1:0] addr_b;
    } cmd_t;

    function automatic op_t decode_op(input logic wr, input logic rd, input logic g);
        if (wr)     return OP_WR;
        else if (rd) return OP_RD;
        else if (g)  return OP_GO;
        else         return OP_NOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_cmd_sequencer_rd_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rd_skid_buffer
// Description : DEPTH-entry FIFO holding {rd_last, data} words returned by
//               the RAM. The occupancy output feeds the read-issue credit
//               check in the sequencer so the FIFO can never overflow.
// Ports       : clk, rst_n      - clock, async active-low reset (flushes)
//               push, push_data - write one entry
//               pop             - remove head entry (only while out_valid)
//               out_valid/data  - head entry
//               occupancy       - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buffer
    import mem_seq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = MEM_DATA_W + 1,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is cleared on reset so the data outputs read 0 while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (push && !pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!push && pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign out_valid = (r_occ != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/mem_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_cmd_sequencer
// Description : Executes decoded commands against the on-chip buffer RAM:
//               single-word writes, inclusive-range burst reads streamed on
//               a valid/ready port, and a go strobe to the compute core.
//               One command at a time; cmd_ready is high only in IDLE.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               cmd_valid/cmd_ready         - command handshake
//               wr_en/rd_en/go + fields     - decoded command
//               mem_we/re/addr/wdata/rdata  - RAM port (1-cycle read latency)
//               rd_valid/data/last/ready    - read stream
//               go_pulse, busy, err         - status
// Options     : MEM_SEQ_REVERSE_EN - when defined, start > end reads
//               descending instead of raising err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_cmd_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int RD_BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              go,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_start_addr,
    input  logic [ADDR_W-1:0] rd_end_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              go_pulse,
    output logic              busy,
    output logic              err
);

    localparam int OCC_W = $clog2(RD_BUF_DEPTH + 1);

    seq_state_t        r_state;
    logic              r_cmd_ready;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [15:0]       r_remaining;
    logic              r_desc;
    logic              r_inflight;
    logic              r_inflight_last;

    cmd_t              w_cmd;
    logic              w_accept;
    logic              w_rng_desc;
    logic              w_rng_err;
    logic              w_desc_next;
    logic [15:0]       w_span_up;
    logic [15:0]       w_span;
    logic              w_issue;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ;
    logic [DATA_W:0]   w_head;

    assign w_cmd.op     = decode_op(wr_en, rd_en, go);
    assign w_cmd.addr_a = wr_en ? wr_addr : rd_start_addr;
    assign w_cmd.addr_b = rd_end_addr;

    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_rng_desc = (w_cmd.addr_a > w_cmd.addr_b);
    // 16 bits so a full 0..0x7FFF range (32768 words) fits.
    assign w_span_up  = 16'(w_cmd.addr_b) - 16'(w_cmd.addr_a) + 16'd1;

`ifdef MEM_SEQ_REVERSE_EN
    logic [15:0] w_span_dn;
    assign w_span_dn   = 16'(w_cmd.addr_a) - 16'(w_cmd.addr_b) + 16'd1;
    assign w_rng_err   = 1'b0;
    assign w_desc_next = w_rng_desc;
    assign w_span      = w_rng_desc ? w_span_dn : w_span_up;
`else
    assign w_rng_err   = w_rng_desc;
    assign w_desc_next = 1'b0;
    assign w_span      = w_span_up;
`endif

    // Issue only when the word can be guaranteed a buffer slot: entries held
    // plus the one in flight, minus the one leaving this cycle. Counting the
    // pop keeps the stream at one word per cycle with a 2-entry buffer.
    assign w_pop   = rd_valid && rd_ready;
    assign w_issue = (r_state == READ) &&
                     ((int'(w_occ) + int'(r_inflight)) < (RD_BUF_DEPTH + int'(w_pop)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cmd_ready     <= 1'b0;
            r_err           <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_remaining     <= '0;
            r_desc          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_err           <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == 16'd1);
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        case (w_cmd.op)
                            OP_WR: begin
                                r_state     <= WRITE;
                                r_cmd_ready <= 1'b0;
                                r_addr      <= w_cmd.addr_a;
                                r_wdata     <= wr_data;
                            end
                            OP_RD: begin
                                if (w_rng_err) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_state     <= READ;
                                    r_cmd_ready <= 1'b0;
                                    r_addr      <= w_cmd.addr_a;
                                    r_remaining <= w_span;
                                    r_desc      <= w_desc_next;
                                end
                            end
                            OP_GO: begin
                                r_state     <= GO;
                                r_cmd_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
                READ: begin
                    if (w_issue) begin
                        r_addr      <= r_desc ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((w_occ == '0) && !r_inflight) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                GO: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Word returned by the RAM this cycle is pushed along with its last flag.
    rd_skid_buffer #(
        .DEPTH (RD_BUF_DEPTH),
        .WIDTH (DATA_W + 1),
        .OCC_W (OCC_W)
    ) u_rd_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data ({r_inflight_last, mem_rdata}),
        .pop       (w_pop),
        .out_valid (rd_valid),
        .out_data  (w_head),
        .occupancy (w_occ)
    );

    assign cmd_ready = r_cmd_ready;
    assign mem_we    = (r_state == WRITE);
    assign mem_re    = w_issue;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rd_data   = w_head[DATA_W-1:0];
    assign rd_last   = w_head[DATA_W] && rd_valid;
    assign go_pulse  = (r_state == GO);
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_cmd_sequencer
// Description : Self-checking bench for mem_cmd_sequencer. A RAM model serves
//               the DUT; a shadow array plus expected-beat and expected-
//               address queues describe what each command must produce.
//               Honors MEM_SEQ_REVERSE_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_cmd_sequencer;

    localparam int AW = 15;
    localparam int DW = 15;
    localparam int NW = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic          wr_en, rd_en, go;
    logic [AW-1:0] wr_addr, rd_start_addr, rd_end_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, rd_data;
    logic          mem_we, mem_re, rd_valid, rd_last, rd_ready;
    logic          go_pulse, busy, err;

    mem_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_en(wr_en), .rd_en(rd_en), .go(go), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start_addr(rd_start_addr), .rd_end_addr(rd_end_addr),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rd_ready(rd_ready), .go_pulse(go_pulse), .busy(busy), .err(err)
    );

    int            total, bad;
    logic [DW-1:0] ram [NW];
    logic [DW-1:0] mdl [NW];
    logic [DW:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];
    int            outst, beat_cnt, go_cnt, exp_go, err_cnt, exp_err, rdy_mode;
    logic          prev_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // RAM: sample the port at negedge, apply it just after the next posedge.
    task automatic ram_proc();
        logic          s_we, s_re;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        forever begin
            @(negedge clk);
            s_we = mem_we; s_re = mem_re; s_a = mem_addr; s_d = mem_wdata;
            @(posedge clk); #1;
            if (s_we) ram[s_a] = s_d;
            if (s_re) mem_rdata = ram[s_a];
        end
    endtask

    task automatic rdy_proc();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic mon_proc();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                addr_q.delete();
                outst      = 0;
                prev_stall = 1'b0;
            end else begin
                if (mem_we) chk("we_re_exclusive", 32'(mem_re), 32'd0);
                if (mem_re) begin
                    if (addr_q.size() == 0) chk("stray_mem_re", 32'(mem_re), 32'd0);
                    else chk("mem_re_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
                    outst++;
                end
                if (prev_stall) chk("stall_keeps_valid", 32'(rd_valid), 32'd1);
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_rd_valid", 32'(rd_valid), 32'd0);
                    end else begin
                        chk("rd_data", 32'(rd_data), 32'(exp_q[0][DW-1:0]));
                        chk("rd_last", 32'(rd_last), 32'(exp_q[0][DW]));
                        if (rd_ready) begin
                            void'(exp_q.pop_front());
                            beat_cnt++;
                        end
                    end
                    if (rd_ready) outst--;
                end
                if (mem_re) chk("outstanding_le2", 32'(outst <= 2), 32'd1);
                prev_stall = rd_valid && !rd_ready;
                if (go_pulse) begin
                    go_cnt++;
                    chk("go_after_reads", 32'(exp_q.size()), 32'd0);
                end
                if (err) err_cnt++;
            end
        end
    endtask

    task automatic push_beat(input int a, input bit lst);
        addr_q.push_back(AW'(a));
        exp_q.push_back({lst, mdl[a]});
    endtask

    // Reference behaviour of one accepted command.
    task automatic model_cmd(input logic w, input logic r, input logic g,
                             input logic [AW-1:0] a0, input logic [DW-1:0] d,
                             input logic [AW-1:0] a1);
        if (w) begin
            mdl[a0] = d;
        end else if (r) begin
            if (a0 <= a1) begin
                for (int a = int'(a0); a <= int'(a1); a++) push_beat(a, a == int'(a1));
            end else begin
`ifdef MEM_SEQ_REVERSE_EN
                for (int a = int'(a0); a >= int'(a1); a--) push_beat(a, a == int'(a1));
`else
                exp_err++;
`endif
            end
        end else if (g) begin
            exp_go++;
        end
    endtask

    // Returns just after the accept edge (cycle N+1).
    task automatic send_cmd(input logic w, input logic r, input logic g,
                            input logic [AW-1:0] a0, input logic [DW-1:0] d,
                            input logic [AW-1:0] a1);
        bit seen;
        @(posedge clk); #1;
        cmd_valid = 1'b1; wr_en = w; rd_en = r; go = g;
        wr_addr = a0; wr_data = d; rd_start_addr = a0; rd_end_addr = a1;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = cmd_ready;
        end
        chk("cmd_ready_wait", 32'(seen), 32'd1);
        if (seen) begin
            model_cmd(w, r, g, a0, d, a1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wr_en = 1'($urandom_range(0, 1)); rd_en = 1'($urandom_range(0, 1));
        go = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom); wr_data = DW'($urandom);
        rd_start_addr = AW'($urandom); rd_end_addr = AW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            done = !busy && cmd_ready && !rd_valid && (exp_q.size() == 0);
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({cmd_ready, mem_we, mem_re, rd_valid, rd_last, go_pulse, busy, err}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        int lat;
        logic [AW-1:0] a0, a1;
        int k;
        total = 0; bad = 0; outst = 0; beat_cnt = 0;
        go_cnt = 0; exp_go = 0; err_cnt = 0; exp_err = 0; prev_stall = 1'b0;
        rst_n = 1'b1; cmd_valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0; go = 1'b0;
        wr_addr = '0; wr_data = '0; rd_start_addr = '0; rd_end_addr = '0;
        mem_rdata = '0; rd_ready = 1'b1; rdy_mode = 0;
        for (int a = 0; a < NW; a++) begin
            ram[a] = DW'(a + 1);
            mdl[a] = DW'(a + 1);
        end
        fork
            ram_proc();
            rdy_proc();
            mon_proc();
        join_none

        // Reset state and release.
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ready_low_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Single write.
        send_cmd(1'b1, 1'b0, 1'b0, 15'h0010, 15'h1234, 15'h0000);
        @(negedge clk);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h0010);
        chk("wr_data", 32'(mem_wdata), 32'h1234);
        chk("wr_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_we_one_cycle", 32'(mem_we), 32'd0);
        chk("wr_ready_n2", 32'(cmd_ready), 32'd1);

        // Burst read without backpressure, first-beat latency.
        rdy_mode = 0; beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0005, 15'h0000, 15'h0008);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (rd_valid) lat = i;
        end
        chk("first_beat_latency", 32'(lat), 32'd3);
        wait_done(100);
        chk("burst4_beats", 32'(beat_cnt), 32'd4);

        // Read back the written word (single-word burst).
        beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0010, 15'h0000, 15'h0010);
        wait_done(100);
        chk("readback_beats", 32'(beat_cnt), 32'd1);

        // Backpressure.
        rdy_mode = 1; beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0005, 15'h0000, 15'h0008);
        wait_done(200);
        chk("bp_beats", 32'(beat_cnt), 32'd4);

        // Top address, one beat.
        rdy_mode = 0; beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h7FFF, 15'h0000, 15'h7FFF);
        wait_done(100);
        chk("top_single_beats", 32'(beat_cnt), 32'd1);

        // Reversed range.
        beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0009, 15'h0000, 15'h0003);
`ifdef MEM_SEQ_REVERSE_EN
        wait_done(200);
        chk("reverse_beats", 32'(beat_cnt), 32'd7);
`else
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_no_re", 32'(mem_re), 32'd0);
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        chk("err_no_beats", 32'(beat_cnt), 32'd0);
`endif

        // go after a read under backpressure.
        rdy_mode = 1;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0000, 15'h0000, 15'h0003);
        send_cmd(1'b0, 1'b0, 1'b1, 15'h0000, 15'h0000, 15'h0000);
        @(negedge clk);
        chk("go_pulse_n1", 32'(go_pulse), 32'd1);
        @(negedge clk);
        chk("go_pulse_one_cycle", 32'(go_pulse), 32'd0);
        chk("go_ready_after", 32'(cmd_ready), 32'd1);

        // Random command mix with random backpressure.
        rdy_mode = 2;
        for (int it = 0; it < 60; it++) begin
            k  = $urandom_range(0, 9);
            a0 = AW'($urandom_range(0, 31));
            a1 = AW'($urandom_range(0, 31));
            case (k)
                0, 1, 2:    send_cmd(1'b1, 1'($urandom_range(0, 1)), 1'b0, a0, DW'($urandom), a1);
                3, 4, 5, 6: send_cmd(1'b0, 1'b1, 1'($urandom_range(0, 1)), a0, DW'($urandom), a1);
                7:          send_cmd(1'b0, 1'b0, 1'b1, a0, DW'($urandom), a1);
                8:          send_cmd(1'b0, 1'b0, 1'b0, a0, DW'($urandom), a1);
                default:    send_cmd(1'b1, 1'b1, 1'b1, a0, DW'($urandom), a1);
            endcase
        end
        wait_done(2000);

        // Full address space.
        rdy_mode = 0; beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0000, 15'h0000, 15'h7FFF);
        wait_done(40000);
        chk("full_range_beats", 32'(beat_cnt), 32'd32768);

        chk("err_count", 32'(err_cnt), 32'(exp_err));
        chk("go_count", 32'(go_cnt), 32'(exp_go));

        // Reset in the middle of a burst.
        rdy_mode = 1;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h0000, 15'h0000, 15'h00FF);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midburst_reset");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rerelease", 32'(cmd_ready), 32'd1);
        send_cmd(1'b1, 1'b0, 1'b0, 15'h0020, 15'h0ABC, 15'h0000);
        @(negedge clk);
        chk("post_reset_we", 32'(mem_we), 32'd1);
        chk("post_reset_wdata", 32'(mem_wdata), 32'h0ABC);
        beat_cnt = 0;
        send_cmd(1'b0, 1'b1, 1'b0, 15'h001F, 15'h0000, 15'h0021);
        wait_done(200);
        chk("post_reset_beats", 32'(beat_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
